// File: rtl/ud_sweep_ctrl.sv
// ud_sweep_ctrl: sequencer for a W-bit up/down counter. Runs NCYC triangle
// sweeps LO->HI->LO (NCYC=0 means run until STOP). HOLD freezes the sweep and
// STOP aborts it. DONE pulses on normal completion, and ERR pulses when START
// is rejected because LO>=HI.
// Ports:
//   C, R                  clock (rising edge), asynchronous active-low reset
//   START, STOP, HOLD     run control
//   LO, HI, NCYC          sweep limits and sweep count, latched at START
//   COUNT                 counter value fed back from the counter
//   UD, CE, LD, LDVAL     counter direction, enable, load strobe, load value
//   BUSY, DONE, ERR, CYC  status outputs and completed-sweep count
module ud_sweep_ctrl #(
  parameter int unsigned W = 4
) (
  input  logic         C,
  input  logic         R,
  input  logic         START,
  input  logic         STOP,
  input  logic         HOLD,
  input  logic [W-1:0] LO,
  input  logic [W-1:0] HI,
  input  logic [W-1:0] NCYC,
  input  logic [W-1:0] COUNT,
  output logic         UD,
  output logic         CE,
  output logic         LD,
  output logic [W-1:0] LDVAL,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR,
  output logic [W-1:0] CYC
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_FIN
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] ncyc_q, ncyc_d;
  logic [W-1:0] cyc_q, cyc_d;
  logic         err_q, err_d;
  logic [W-1:0] cyc_inc;

  assign cyc_inc = cyc_q + W'(1);

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    ncyc_d  = ncyc_q;
    cyc_d   = cyc_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (LO < HI) begin
            lo_d    = LO;
            hi_d    = HI;
            ncyc_d  = NCYC;
            cyc_d   = '0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: state_d = STOP ? S_IDLE : S_UP;
      // Limit tests use >= / <= so that a counter disturbed past a limit
      // turns around immediately instead of running on and wrapping.
      S_UP: begin
        if (STOP) begin
          state_d = S_IDLE;
        end else if (!HOLD && (COUNT >= hi_q)) begin
          state_d = S_DOWN;
        end
      end
      S_DOWN: begin
        if (STOP) begin
          state_d = S_IDLE;
        end else if (!HOLD && (COUNT <= lo_q)) begin
          cyc_d   = cyc_inc;
          state_d = ((ncyc_q != '0) && (cyc_inc == ncyc_q)) ? S_FIN : S_UP;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      ncyc_q  <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ncyc_q  <= ncyc_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    CE = 1'b0;
    if (state_q == S_UP) begin
      CE = (COUNT < hi_q) && !HOLD && !STOP;
    end else if (state_q == S_DOWN) begin
      CE = (COUNT > lo_q) && !HOLD && !STOP;
    end
  end

  assign UD    = (state_q == S_UP);
  assign LD    = (state_q == S_LOAD);
  assign LDVAL = lo_q;
  assign BUSY  = (state_q == S_LOAD) || (state_q == S_UP) || (state_q == S_DOWN);
  assign DONE  = (state_q == S_FIN);
  assign ERR   = err_q;
  assign CYC   = cyc_q;

endmodule

// File: tb/tb_ud_sweep_ctrl.sv
module tb_ud_sweep_ctrl;
  localparam int W = 4;

  logic         C = 1'b0;
  logic         R, START, STOP, HOLD;
  logic [W-1:0] LO, HI, NCYC;
  logic [W-1:0] COUNT;
  logic         UD, CE, LD, BUSY, DONE, ERR;
  logic [W-1:0] LDVAL, CYC;
  logic         dist_en;
  logic [W-1:0] dist_val;
  int           checks = 0;
  int           errors = 0;

  ud_sweep_ctrl #(.W(W)) dut (
    .C(C), .R(R), .START(START), .STOP(STOP), .HOLD(HOLD),
    .LO(LO), .HI(HI), .NCYC(NCYC), .COUNT(COUNT),
    .UD(UD), .CE(CE), .LD(LD), .LDVAL(LDVAL),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CYC(CYC)
  );

  always #5 C = ~C;

  // Up/down counter with CE and synchronous load; dist_en lets the bench
  // disturb the count externally.
  always @(posedge C or negedge R) begin
    if (!R)           COUNT <= '0;
    else if (dist_en) COUNT <= dist_val;
    else if (LD)      COUNT <= LDVAL;
    else if (CE)      COUNT <= UD ? COUNT + 4'd1 : COUNT - 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference sweep: position p within a period of 2*span+2 cycles; the first
  // span+1 positions climb lo..hi, the rest descend hi..lo.
  function automatic int m_cnt(int lo, int hi, int k);
    int span = hi - lo;
    int p = k % (2 * span + 2);
    return (p <= span) ? lo + p : hi - (p - span - 1);
  endfunction
  function automatic int m_ud(int lo, int hi, int k);
    int span = hi - lo;
    return ((k % (2 * span + 2)) <= span) ? 1 : 0;
  endfunction
  function automatic int m_ce(int lo, int hi, int k);
    int span = hi - lo;
    int p = k % (2 * span + 2);
    return (p <= span) ? int'(p < span) : int'((p - span - 1) < span);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ud"}, 32'(UD), 0);       chk({tag, "_ce"}, 32'(CE), 0);
    chk({tag, "_ld"}, 32'(LD), 0);       chk({tag, "_ldval"}, 32'(LDVAL), 0);
    chk({tag, "_busy"}, 32'(BUSY), 0);   chk({tag, "_done"}, 32'(DONE), 0);
    chk({tag, "_err"}, 32'(ERR), 0);     chk({tag, "_cyc"}, 32'(CYC), 0);
  endtask

  task automatic run_sweeps(input int lo, input int hi, input int nc, input int hold_k,
                            input int hold_len, input bit rnd, input int stop_k);
    int per, lim, nh;
    per = 2 * (hi - lo) + 2;
    lim = (stop_k >= 0) ? stop_k : nc * per;
    @(posedge C); #1;
    LO = W'(lo); HI = W'(hi); NCYC = W'(nc); START = 1'b1;
    @(posedge C); #1;
    START = 1'b0;
    LO = W'($urandom); HI = W'($urandom); NCYC = W'($urandom);
    #1;
    chk("load_ld", 32'(LD), 1);       chk("load_ldval", 32'(LDVAL), lo);
    chk("load_busy", 32'(BUSY), 1);   chk("load_ud", 32'(UD), 0);
    chk("load_cyc", 32'(CYC), 0);
    @(posedge C); #1;
    for (int k = 0; k < lim; k++) begin
      if (k == hold_k) nh = hold_len;
      else if (rnd && ($urandom_range(0, 7) == 0)) nh = int'($urandom_range(1, 3));
      else nh = 0;
      for (int h = 0; h < nh; h++) begin
        HOLD = 1'b1; #1;
        chk("hold_ce", 32'(CE), 0);
        chk("hold_cnt", 32'(COUNT), m_cnt(lo, hi, k));
        chk("hold_ud", 32'(UD), m_ud(lo, hi, k));
        chk("hold_cyc", 32'(CYC), k / per);
        @(posedge C); #1;
      end
      HOLD = 1'b0;
      START = rnd && ($urandom_range(0, 7) == 0);
      #1;
      chk("cnt", 32'(COUNT), m_cnt(lo, hi, k));
      chk("ud", 32'(UD), m_ud(lo, hi, k));
      chk("ce", 32'(CE), m_ce(lo, hi, k));
      chk("cyc", 32'(CYC), k / per);
      chk("busy", 32'(BUSY), 1);   chk("done_run", 32'(DONE), 0);
      chk("err_run", 32'(ERR), 0); chk("ld_run", 32'(LD), 0);
      @(posedge C); #1;
    end
    START = 1'b0;
    if (stop_k >= 0) begin
      STOP = 1'b1; #1;
      chk("stop_ce", 32'(CE), 0);
      chk("stop_ud", 32'(UD), m_ud(lo, hi, lim));
      chk("stop_cnt", 32'(COUNT), m_cnt(lo, hi, lim));
      @(posedge C); #1;
      STOP = 1'b0; #1;
      chk("stop_busy", 32'(BUSY), 0);  chk("stop_done", 32'(DONE), 0);
      chk("stop_ud_idle", 32'(UD), 0);
      chk("stop_cnt_frz", 32'(COUNT), m_cnt(lo, hi, lim));
      chk("stop_cyc", 32'(CYC), lim / per);
      @(posedge C); #1;
      chk("stop_done2", 32'(DONE), 0);
    end else begin
      #1;
      chk("fin_done", 32'(DONE), 1);  chk("fin_busy", 32'(BUSY), 0);
      chk("fin_cyc", 32'(CYC), nc);   chk("fin_ud", 32'(UD), 0);
      chk("fin_cnt", 32'(COUNT), lo); chk("fin_ce", 32'(CE), 0);
      @(posedge C); #1;
      chk("idle_done", 32'(DONE), 0); chk("idle_cyc", 32'(CYC), nc);
      chk("idle_busy", 32'(BUSY), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, hi;
    R = 1'b0; START = 1'b0; STOP = 1'b0; HOLD = 1'b0;
    LO = '0; HI = '0; NCYC = '0; dist_en = 1'b0; dist_val = '0;
    #3;
    chk_all_zero("rst");
    #4 R = 1'b1;
    @(posedge C); #1;
    chk_all_zero("post_rst");

    // Basic single sweep and full-range sweeps.
    run_sweeps(2, 5, 1, -1, 0, 1'b0, -1);
    run_sweeps(0, 15, 3, -1, 0, 1'b0, -1);
    // Six-cycle HOLD at COUNT=7 while climbing.
    run_sweeps(3, 10, 1, 4, 6, 1'b0, -1);
    // STOP while descending at COUNT=4, second sweep of an endless run.
    run_sweeps(1, 6, 0, -1, 0, 1'b0, 12 + 8);

    // Rejected STARTs.
    for (int i = 0; i < 2; i++) begin
      @(posedge C); #1;
      LO = (i == 0) ? 4'd6 : 4'd11;
      HI = (i == 0) ? 4'd6 : 4'd3;
      START = 1'b1; #1;
      chk("err_pre", 32'(ERR), 0);
      @(posedge C); #1;
      START = 1'b0; #1;
      chk("err_pulse", 32'(ERR), 1); chk("err_busy", 32'(BUSY), 0);
      chk("err_ld", 32'(LD), 0);
      @(posedge C); #1;
      chk("err_clr", 32'(ERR), 0);   chk("err_busy2", 32'(BUSY), 0);
    end

    // Counter disturbed above HI while climbing, then below LO while descending.
    @(posedge C); #1;
    LO = 4'd4; HI = 4'd8; NCYC = 4'd0; START = 1'b1;
    @(posedge C); #1; START = 1'b0;
    @(posedge C); #1;
    @(posedge C); #1;
    dist_en = 1'b1; dist_val = 4'd12;
    @(posedge C); #1;
    dist_en = 1'b0; #1;
    chk("dis_hi_cnt", 32'(COUNT), 12); chk("dis_hi_ud", 32'(UD), 1);
    chk("dis_hi_ce", 32'(CE), 0);
    @(posedge C); #1; #1;
    chk("dis_dn_ud", 32'(UD), 0);      chk("dis_dn_ce", 32'(CE), 1);
    @(posedge C); #1;
    dist_en = 1'b1; dist_val = 4'd1;
    @(posedge C); #1;
    dist_en = 1'b0; #1;
    chk("dis_lo_ce", 32'(CE), 0);      chk("dis_lo_ud", 32'(UD), 0);
    chk("dis_lo_cyc", 32'(CYC), 0);
    @(posedge C); #1; #1;
    chk("dis_up_ud", 32'(UD), 1);      chk("dis_up_ce", 32'(CE), 1);
    chk("dis_up_cyc", 32'(CYC), 1);    chk("dis_up_cnt", 32'(COUNT), 1);
    @(posedge C); #1; #1;
    chk("dis_up_cnt2", 32'(COUNT), 2);
    STOP = 1'b1;
    @(posedge C); #1;
    STOP = 1'b0; #1;
    chk("dis_stop_busy", 32'(BUSY), 0);

    // Asynchronous reset in the middle of the second sweep.
    @(posedge C); #1;
    LO = 4'd2; HI = 4'd9; NCYC = 4'd2; START = 1'b1;
    @(posedge C); #1; START = 1'b0;
    repeat (21) @(posedge C);
    #1;
    chk("mid_busy", 32'(BUSY), 1); chk("mid_cyc", 32'(CYC), 1);
    #2 R = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_cnt", 32'(COUNT), 0);
    #2 R = 1'b1;
    run_sweeps(2, 9, 1, -1, 0, 1'b0, -1);

    // Randomized runs with random HOLDs and ignored STARTs.
    for (int i = 0; i < 4; i++) begin
      lo = int'($urandom_range(0, 14));
      hi = int'($urandom_range(lo + 1, 15));
      run_sweeps(lo, hi, int'($urandom_range(1, 3)), -1, 0, 1'b1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
